// File: rtl/cpu_result_merge_if.sv
// rtl/cpu_result_merge_if.sv - producer/sink bus for the writeback merge unit
interface cpu_result_merge_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*DEST_W-1:0] in_dest;
    logic                     out_valid;
    logic                     out_ready;
    logic [DEST_W-1:0]        out_dest;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_chan;

    modport master (
        output in_valid, in_data, in_dest, out_ready,
        input  out_valid, out_dest, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, in_dest, out_ready,
        output out_valid, out_dest, out_data, out_chan
    );
endinterface

// File: rtl/cpu_result_merge.sv
// rtl/cpu_result_merge.sv - per-channel result FIFOs merged into one writeback stream
module cpu_result_merge #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int DEST_W   = 5,
    parameter int ARB_MODE = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    cpu_result_merge_if.slave   bus,
    output logic [NUM_CH-1:0]   fifo_empty,
    output logic [NUM_CH-1:0]   overflow,
    output logic                overflow_any
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem_data [NUM_CH][DEPTH];
    logic [DEST_W-1:0] r_mem_dest [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr   [NUM_CH];
    logic [PTR_W-1:0]  r_rd_ptr   [NUM_CH];
    logic [CNT_W-1:0]  r_count    [NUM_CH];
    logic [NUM_CH-1:0] r_overflow;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_out_valid;
    logic [DEST_W-1:0] r_out_dest;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_chan;

    logic              w_load;
    logic              w_found;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W-1:0]   w_cand;
    logic [NUM_CH-1:0] w_nonempty;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_drop;

    assign w_load       = !r_out_valid || bus.out_ready;
    assign fifo_empty   = ~w_nonempty;
    assign overflow     = r_overflow;
    assign overflow_any = |r_overflow;

    assign bus.out_valid = r_out_valid;
    assign bus.out_dest  = r_out_dest;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_nonempty[c] = (r_count[c] != '0);
        end
    end

    // Search order starts after the last grant (round-robin) or at channel 0 (fixed).
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = (ARB_MODE != 0) ? CH_W'(i) : CH_W'((int'(r_rr_ptr) + 1 + i) % NUM_CH);
            if (!w_found && w_nonempty[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // A full channel still accepts when it is popped on the same edge.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pop[c] = w_load && w_found && (w_grant == CH_W'(c));
            if (bus.in_valid[c] && (bus.in_dest[c*DEST_W +: DEST_W] != '0)) begin
                if ((r_count[c] != CNT_W'(DEPTH)) || w_pop[c]) begin
                    w_push[c] = 1'b1;
                end else begin
                    w_drop[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) begin
                r_mem_data[c][r_wr_ptr[c]] <= bus.in_data[c*DATA_W +: DATA_W];
                r_mem_dest[c][r_wr_ptr[c]] <= bus.in_dest[c*DEST_W +: DEST_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_overflow  <= '0;
            r_rr_ptr    <= CH_W'(NUM_CH - 1);
            r_out_valid <= 1'b0;
            r_out_dest  <= '0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                r_count[c] <= r_count[c] + CNT_W'(w_push[c]) - CNT_W'(w_pop[c]);
                if (w_drop[c]) r_overflow[c] <= 1'b1;
            end
            if (w_load) begin
                if (w_found) begin
                    r_out_valid <= 1'b1;
                    r_out_dest  <= r_mem_dest[w_grant][r_rd_ptr[w_grant]];
                    r_out_data  <= r_mem_data[w_grant][r_rd_ptr[w_grant]];
                    r_out_chan  <= w_grant;
                    r_rr_ptr    <= w_grant;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_result_merge.sv
// tb/tb_cpu_result_merge.sv - round-robin and fixed-priority units against a queue model
module tb_cpu_result_merge;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int CH_W   = 2;
    localparam int E_W    = DEST_W + DATA_W;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [NUM_CH-1:0]        tb_valid;
    logic [NUM_CH*DATA_W-1:0] tb_data;
    logic [NUM_CH*DEST_W-1:0] tb_dest;
    logic                     tb_ready;

    cpu_result_merge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W)) bus_rr ();
    cpu_result_merge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W)) bus_fp ();

    assign bus_rr.in_valid  = tb_valid;
    assign bus_rr.in_data   = tb_data;
    assign bus_rr.in_dest   = tb_dest;
    assign bus_rr.out_ready = tb_ready;
    assign bus_fp.in_valid  = tb_valid;
    assign bus_fp.in_data   = tb_data;
    assign bus_fp.in_dest   = tb_dest;
    assign bus_fp.out_ready = tb_ready;

    logic [NUM_CH-1:0] fe_rr, ovf_rr, fe_fp, ovf_fp;
    logic              ova_rr, ova_fp;

    cpu_result_merge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W), .ARB_MODE(0)) dut_rr (
        .clock(clock), .reset_n(reset_n), .bus(bus_rr.slave),
        .fifo_empty(fe_rr), .overflow(ovf_rr), .overflow_any(ova_rr)
    );
    cpu_result_merge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W), .ARB_MODE(1)) dut_fp (
        .clock(clock), .reset_n(reset_n), .bus(bus_fp.slave),
        .fifo_empty(fe_fp), .overflow(ovf_fp), .overflow_any(ova_fp)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: one queue per channel per unit (unit 0 round-robin, unit 1 fixed priority).
    logic [E_W-1:0]    mq [2*NUM_CH][$];
    logic              m_ov   [2];
    logic [DEST_W-1:0] m_od   [2];
    logic [DATA_W-1:0] m_odat [2];
    logic [CH_W-1:0]   m_oc   [2];
    int                m_rr   [2];
    logic [NUM_CH-1:0] m_ovf  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ov[u] = 1'b0; m_od[u] = '0; m_odat[u] = '0; m_oc[u] = '0;
            m_rr[u] = NUM_CH - 1; m_ovf[u] = '0;
            for (int c = 0; c < NUM_CH; c++) mq[u*NUM_CH+c].delete();
        end
    endtask

    task automatic model_step(input int u);
        int pre [NUM_CH];
        int g;
        int cand;
        logic [E_W-1:0]    e;
        logic [DEST_W-1:0] d;
        g = -1;
        for (int c = 0; c < NUM_CH; c++) pre[c] = mq[u*NUM_CH+c].size();
        if (!m_ov[u] || tb_ready) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = (u == 1) ? i : (m_rr[u] + 1 + i) % NUM_CH;
                if (g < 0 && pre[cand] > 0) g = cand;
            end
            if (g >= 0) begin
                e = mq[u*NUM_CH+g].pop_front();
                m_ov[u] = 1'b1; m_od[u] = e[E_W-1:DATA_W]; m_odat[u] = e[DATA_W-1:0];
                m_oc[u] = g[CH_W-1:0]; m_rr[u] = g;
            end else begin
                m_ov[u] = 1'b0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            d = tb_dest[c*DEST_W +: DEST_W];
            if (tb_valid[c] && d != '0) begin
                if (pre[c] < DEPTH || g == c) mq[u*NUM_CH+c].push_back({d, tb_data[c*DATA_W +: DATA_W]});
                else m_ovf[u][c] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] fe [2];
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < NUM_CH; c++) fe[u][c] = (mq[u*NUM_CH+c].size() == 0);
        chk("rr_valid", bus_rr.out_valid, m_ov[0]);
        chk("rr_dest",  bus_rr.out_dest,  m_od[0]);
        chk("rr_data",  bus_rr.out_data,  m_odat[0]);
        chk("rr_chan",  bus_rr.out_chan,  m_oc[0]);
        chk("rr_empty", fe_rr,  fe[0]);
        chk("rr_ovf",   ovf_rr, m_ovf[0]);
        chk("rr_ovany", ova_rr, |m_ovf[0]);
        chk("fp_valid", bus_fp.out_valid, m_ov[1]);
        chk("fp_dest",  bus_fp.out_dest,  m_od[1]);
        chk("fp_data",  bus_fp.out_data,  m_odat[1]);
        chk("fp_chan",  bus_fp.out_chan,  m_oc[1]);
        chk("fp_empty", fe_fp,  fe[1]);
        chk("fp_ovf",   ovf_fp, m_ovf[1]);
        chk("fp_ovany", ova_fp, |m_ovf[1]);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        compare();
    endtask

    task automatic clear_in();
        tb_valid = '0; tb_data = '0; tb_dest = '0;
    endtask

    task automatic set_push(input int ch, input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] v);
        tb_valid[ch] = 1'b1;
        tb_dest[ch*DEST_W +: DEST_W] = d;
        tb_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_in();
        model_reset();
        @(negedge clock);
        compare();
        reset_n = 1'b1;
    endtask

    int fp_ch [$];
    int fp_dat [$];

    initial begin
        reset_n = 1'b0; tb_ready = 1'b0;
        clear_in();
        model_reset();
        repeat (2) @(negedge clock);
        compare();
        chk("reset_empty", fe_rr, 4'hf);
        chk("reset_valid", bus_rr.out_valid, 1'b0);
        reset_n = 1'b1;

        // single result: one cycle of buffering, then one presented cycle
        tb_ready = 1'b1;
        set_push(2, 5'd7, 32'hDEADBEEF);
        cycle();
        clear_in();
        chk("single_lat", bus_rr.out_valid, 1'b0);
        cycle();
        chk("single_valid", bus_rr.out_valid, 1'b1);
        chk("single_dest",  bus_rr.out_dest,  5'd7);
        chk("single_data",  bus_rr.out_data,  32'hDEADBEEF);
        chk("single_chan",  bus_rr.out_chan,  2'd2);
        cycle();
        chk("single_drop",  bus_rr.out_valid, 1'b0);

        // round-robin from fresh reset
        do_reset();
        tb_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_push(c, DEST_W'(c + 1), DATA_W'(32'h100 + c));
        cycle();
        clear_in();
        for (int i = 0; i < NUM_CH; i++) begin
            cycle();
            chk("rr_seq", bus_rr.out_chan, i);
        end
        cycle();
        chk("rr_done", bus_rr.out_valid, 1'b0);

        // fixed priority: ch0 drains before ch3
        do_reset();
        tb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clear_in();
            if (k < 3) begin
                set_push(0, 5'd3, DATA_W'(32'h10 + k));
                set_push(3, 5'd9, DATA_W'(32'h30 + k));
            end
            cycle();
            if (bus_fp.out_valid) begin
                fp_ch.push_back(int'(bus_fp.out_chan));
                fp_dat.push_back(int'(bus_fp.out_data));
            end
        end
        clear_in();
        chk("fp_count", fp_ch.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < fp_ch.size()) begin
                chk("fp_order_ch",   fp_ch[i],  (i < 3) ? 0 : 3);
                chk("fp_order_data", fp_dat[i], (i < 3) ? (32'h10 + i) : (32'h30 + i - 3));
            end
        end

        // backpressure and overflow
        do_reset();
        tb_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            clear_in();
            set_push(1, 5'd1, DATA_W'(k));
            cycle();
        end
        clear_in();
        chk("bp_hold", bus_rr.out_data, 32'd1);
        chk("bp_ovf",  ovf_rr, 4'b0010);
        chk("bp_any",  ova_rr, 1'b1);
        chk("bp_empty", fe_rr, 4'b1101);
        tb_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("bp_drain_v", bus_rr.out_valid, 1'b1);
            chk("bp_drain_d", bus_rr.out_data, DATA_W'(k));
            cycle();
        end
        chk("bp_done", bus_rr.out_valid, 1'b0);
        chk("bp_sticky", ovf_rr, 4'b0010);

        // full channel with simultaneous push and pop, then dest=0 pushes
        do_reset();
        tb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clear_in();
            set_push(1, 5'd2, DATA_W'(32'h50 + k));
            cycle();
        end
        tb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            clear_in();
            set_push(1, 5'd2, DATA_W'(32'h60 + k));
            cycle();
            chk("full_ovf", ovf_rr, 4'b0000);
        end
        for (int k = 0; k < 8; k++) begin
            clear_in();
            set_push(1, 5'd0, DATA_W'(32'h70 + k));
            cycle();
        end
        clear_in();
        chk("dest0_valid", bus_rr.out_valid, 1'b0);
        chk("dest0_ovf",   ovf_rr, 4'b0000);
        chk("dest0_empty", fe_rr,  4'hf);

        // asynchronous reset between edges
        tb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NUM_CH; c++) set_push(c, DEST_W'(c + 4), $urandom);
            cycle();
        end
        clear_in();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", bus_rr.out_valid, 1'b0);
        chk("async_empty", fe_rr, 4'hf);
        chk("async_fp_empty", fe_fp, 4'hf);
        model_reset();
        @(negedge clock);
        compare();
        reset_n = 1'b1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tb_valid[c] = ($urandom_range(0, 99) < 35);
                tb_dest[c*DEST_W +: DEST_W] = ($urandom_range(0, 7) == 0) ? '0 : DEST_W'($urandom);
                tb_data[c*DATA_W +: DATA_W] = $urandom;
            end
            tb_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
